// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_types
//   Shared types for the mp3 memory arbiter: word/address/mask typedefs, the
//   arbiter FSM state encoding and the byte mask used for every read.
//   ADDR_WIDTH / DATA_WIDTH / MASK_WIDTH are the arbiter's width parameters;
//   every file in the arbiter picks them up through this package.
// -----------------------------------------------------------------------------
package lc3b_types;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef logic [DATA_WIDTH-1:0] lc3b_word;
  typedef logic [ADDR_WIDTH-1:0] lc3b_addr;
  typedef logic [MASK_WIDTH-1:0] lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    GAP     = 2'd3
  } arb_state_t;

  // Reads always present a full-word mask to memory.
  localparam lc3b_mem_wmask READ_MASK = '1;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the fetch port (i_*), the data port (d_*) and the physical memory
//   port (mem_*) seen by the arbiter.
//   Modports:
//     master : arbiter view -- takes client requests and memory replies,
//              drives client responses and the memory strobes/fields.
//     slave  : environment view (clients plus memory), the mirror image.
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  import lc3b_types::*;

  // fetch client (read-only)
  logic          i_read;
  lc3b_addr      i_address;
  lc3b_word      i_rdata;
  logic          i_resp;

  // data client (read/write)
  logic          d_read;
  logic          d_write;
  lc3b_addr      d_address;
  lc3b_word      d_wdata;
  lc3b_mem_wmask d_byte_enable;
  lc3b_word      d_rdata;
  logic          d_resp;

  // physical memory port
  logic          mem_read;
  logic          mem_write;
  lc3b_addr      mem_address;
  lc3b_word      mem_wdata;
  lc3b_mem_wmask mem_byte_enable;
  lc3b_word      mem_rdata;
  logic          mem_resp;

  modport master (
    input  i_read, i_address,
    input  d_read, d_write, d_address, d_wdata, d_byte_enable,
    input  mem_rdata, mem_resp,
    output i_rdata, i_resp,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );

  modport slave (
    output i_read, i_address,
    output d_read, d_write, d_address, d_wdata, d_byte_enable,
    output mem_rdata, mem_resp,
    input  i_rdata, i_resp,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );

endinterface

// File: rtl/mem_arbiter_req_latch.sv
// -----------------------------------------------------------------------------
// arb_req_latch
//   Register bundle holding the granted request (address, write data, mask,
//   read/write flags). Loaded once at grant and held until the next grant, so
//   client inputs may wander during service without disturbing memory.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     load_i              capture the *_i fields this cycle
//     addr_i .. write_i   request fields (already muxed between clients)
//     addr_o .. write_o   held fields
//   Reset values: address/wdata 0, mask all-ones, no read/write pending.
// -----------------------------------------------------------------------------
module arb_req_latch
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  lc3b_addr      addr_i,
  input  lc3b_word      wdata_i,
  input  lc3b_mem_wmask mask_i,
  input  logic          read_i,
  input  logic          write_i,
  output lc3b_addr      addr_o,
  output lc3b_word      wdata_o,
  output lc3b_mem_wmask mask_o,
  output logic          read_o,
  output logic          write_o
);

  lc3b_addr      addr_q;
  lc3b_word      wdata_q;
  lc3b_mem_wmask mask_q;
  logic          read_q;
  logic          write_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= READ_MASK;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else if (load_i) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      mask_q  <= mask_i;
      read_q  <= read_i;
      write_q <= write_i;
    end
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign mask_o  = mask_q;
  assign read_o  = read_q;
  assign write_o = write_q;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-client arbiter for the mp3 core: instruction fetch (read-only) and
//   data memory (read/write) share one physical memory port. A Moore FSM
//   (IDLE -> SERVE_I/SERVE_D -> GAP -> IDLE) grants one client at a time; the
//   request is captured at grant and held for the whole transaction, the
//   memory reply is passed straight back to the granted client, and a forced
//   GAP cycle guarantees memory sees the strobe drop between transactions.
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-high reset
//     bus   mem_arbiter_if.master (fetch, data and memory ports)
//   Configuration:
//     MEM_ARBITER_ROUND_ROBIN_EN  defined: a priority flag flips after every
//       completed transaction and decides simultaneous requests.
//       undefined: data always beats fetch.
// -----------------------------------------------------------------------------
module mem_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  arb_state_t    state_q, state_d;

  logic          d_req;
  logic          pick_d;     // data client wins if a grant is made now
  logic          load;
  logic          done;       // memory completed the current transaction

  lc3b_addr      lat_addr_d;
  lc3b_word      lat_wdata_d;
  lc3b_mem_wmask lat_mask_d;
  logic          lat_read_d, lat_write_d;

  lc3b_addr      lat_addr_q;
  lc3b_word      lat_wdata_q;
  lc3b_mem_wmask lat_mask_q;
  logic          lat_read_q, lat_write_q;

  assign d_req = bus.d_read | bus.d_write;
  assign done  = ((state_q == SERVE_I) || (state_q == SERVE_D)) && bus.mem_resp;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // 1 = data client preferred on a tie, 0 = fetch preferred.
  logic prio_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_d_q <= 1'b1;
    end else if (done) begin
      prio_d_q <= ~prio_d_q;
    end
  end

  // Data loses only when fetch is also asking and the flag points at fetch.
  assign pick_d = d_req & (prio_d_q | ~bus.i_read);
`else
  assign pick_d = d_req;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = SERVE_D;
        end else if (bus.i_read) begin
          state_d = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_resp) begin
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture. The latch is shared by both clients; the mux picks the
  // winner's fields. Write takes precedence if a data client raises both
  // d_read and d_write, so read is only flagged when write is absent.
  // ---------------------------------------------------------------------------
  assign load = (state_q == IDLE) && (d_req || bus.i_read);

  always_comb begin
    lat_addr_d  = bus.i_address;
    lat_wdata_d = '0;
    lat_mask_d  = READ_MASK;
    lat_read_d  = 1'b1;
    lat_write_d = 1'b0;
    if (pick_d) begin
      lat_addr_d  = bus.d_address;
      lat_wdata_d = bus.d_wdata;
      lat_mask_d  = bus.d_write ? bus.d_byte_enable : READ_MASK;
      lat_read_d  = ~bus.d_write;
      lat_write_d = bus.d_write;
    end
  end

  arb_req_latch u_req_latch (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .addr_i  (lat_addr_d),
    .wdata_i (lat_wdata_d),
    .mask_i  (lat_mask_d),
    .read_i  (lat_read_d),
    .write_i (lat_write_d),
    .addr_o  (lat_addr_q),
    .wdata_o (lat_wdata_q),
    .mask_o  (lat_mask_q),
    .read_o  (lat_read_q),
    .write_o (lat_write_q)
  );

  // ---------------------------------------------------------------------------
  // Outputs. Strobes depend only on state and held request flags; the client
  // responses are a same-cycle pass-through of mem_resp gated by the grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.i_resp          = 1'b0;
    bus.d_resp          = 1'b0;
    bus.mem_address     = lat_addr_q;
    bus.mem_wdata       = lat_wdata_q;
    bus.mem_byte_enable = lat_mask_q;
    bus.i_rdata         = bus.mem_rdata;
    bus.d_rdata         = bus.mem_rdata;
    case (state_q)
      SERVE_I: begin
        bus.mem_read = lat_read_q;
        bus.i_resp   = bus.mem_resp;
      end
      SERVE_D: begin
        bus.mem_read  = lat_read_q;
        bus.mem_write = lat_write_q;
        bus.d_resp    = bus.mem_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed scenarios followed by randomized request mixes. The bench plays
//   both clients and the memory; a word array stands in for memory contents,
//   and the grant order comes from the arbitration rule (data first, or the
//   alternating flag when MEM_ARBITER_ROUND_ROBIN_EN is defined).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int       n_checks = 0;
  int       n_fail   = 0;
  bit       prio_d   = 1'b1;   // model of the tie-break flag (1 = data)
  lc3b_word ref_mem [256];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_strobes(input string tag, input bit rd, input bit wr,
                             input lc3b_addr addr, input lc3b_word wdata,
                             input lc3b_mem_wmask be);
    chk1 ({tag, "_mem_read"},  bus.mem_read,  rd);
    chk1 ({tag, "_mem_write"}, bus.mem_write, wr);
    chk16({tag, "_mem_addr"},  bus.mem_address, addr);
    chk16({tag, "_mem_be"},    16'(bus.mem_byte_enable), 16'(be));
    if (wr) chk16({tag, "_mem_wdata"}, bus.mem_wdata, wdata);
  endtask

  // Called at the first cycle of service. Holds the strobe for 'lat' cycles
  // while scrambling the served client's fields, then returns mem_resp, then
  // checks the GAP cycle. Returns early in the GAP cycle.
  task automatic serve(input bit is_d, input bit rd, input bit wr,
                       input lc3b_addr addr, input lc3b_word wdata,
                       input lc3b_mem_wmask be, input int lat,
                       input lc3b_word rdata, input string tag);
    for (int c = 0; c < lat; c++) begin
      chk_strobes({tag, "_wait"}, rd, wr, addr, wdata, be);
      chk1({tag, "_iresp_wait"}, bus.i_resp, 1'b0);
      chk1({tag, "_dresp_wait"}, bus.d_resp, 1'b0);
      if (is_d) begin
        bus.d_address     = lc3b_addr'($urandom);
        bus.d_wdata       = lc3b_word'($urandom);
        bus.d_byte_enable = lc3b_mem_wmask'($urandom);
      end else begin
        bus.i_address     = lc3b_addr'($urandom);
      end
      tick();
    end
    bus.mem_rdata = rdata;
    bus.mem_resp  = 1'b1;
    #1;
    chk_strobes({tag, "_resp"}, rd, wr, addr, wdata, be);
    chk1({tag, "_i_resp"}, bus.i_resp, !is_d);
    chk1({tag, "_d_resp"}, bus.d_resp, is_d);
    if (rd) chk16({tag, "_rdata"}, is_d ? bus.d_rdata : bus.i_rdata, rdata);
    tick();
    bus.mem_resp = 1'b0;
    #1;
    chk1({tag, "_gap_read"},  bus.mem_read,  1'b0);
    chk1({tag, "_gap_write"}, bus.mem_write, 1'b0);
    chk1({tag, "_gap_iresp"}, bus.i_resp,    1'b0);
    chk1({tag, "_gap_dresp"}, bus.d_resp,    1'b0);
    prio_d = ~prio_d;
  endtask

  task automatic serve_d(input bit rd, input bit wr, input lc3b_addr addr,
                         input lc3b_word wdata, input lc3b_mem_wmask be,
                         input int lat, input string tag);
    bit            is_wr = wr;
    lc3b_mem_wmask exp_be = is_wr ? be : READ_MASK;
    lc3b_word      rdata  = ref_mem[addr[7:0]];
    if (!rd && !wr) return;
    serve(1'b1, !is_wr, is_wr, addr, wdata, exp_be, lat, rdata, tag);
    if (is_wr) begin
      for (int b = 0; b < MASK_WIDTH; b++)
        if (be[b]) ref_mem[addr[7:0]][8*b +: 8] = wdata[8*b +: 8];
    end
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
  endtask

  task automatic serve_i(input lc3b_addr addr, input int lat, input string tag);
    serve(1'b0, 1'b1, 1'b0, addr, '0, READ_MASK, lat, ref_mem[addr[7:0]], tag);
    bus.i_read = 1'b0;
  endtask

  // Raise the requested mix in IDLE, serve both clients in model order and
  // return one cycle after the final GAP, i.e. in IDLE again.
  task automatic do_txns(input bit drd, input bit dwr, input lc3b_addr daddr,
                         input lc3b_word dwdata, input lc3b_mem_wmask dbe,
                         input bit ireq, input lc3b_addr iaddr,
                         input int lat_d, input int lat_i, input string tag);
    bit dreq    = drd | dwr;
    bit first_d = dreq;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    if (dreq && ireq) first_d = prio_d;
`endif
    bus.d_read        = drd;
    bus.d_write       = dwr;
    bus.d_address     = daddr;
    bus.d_wdata       = dwdata;
    bus.d_byte_enable = dbe;
    bus.i_read        = ireq;
    bus.i_address     = iaddr;
    tick();
    if (first_d) begin
      serve_d(drd, dwr, daddr, dwdata, dbe, lat_d, {tag, "_d"});
      if (ireq) begin
        tick();
        chk1({tag, "_idle_read"}, bus.mem_read, 1'b0);
        tick();
        serve_i(iaddr, lat_i, {tag, "_i"});
      end
    end else if (ireq) begin
      serve_i(iaddr, lat_i, {tag, "_i"});
      if (dreq) begin
        tick();
        chk1({tag, "_idle_read"}, bus.mem_read, 1'b0);
        tick();
        serve_d(drd, dwr, daddr, dwdata, dbe, lat_d, {tag, "_d"});
      end
    end
    tick();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) ref_mem[k] = lc3b_word'($urandom);
    bus.i_read = 0; bus.i_address = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_address = '0;
    bus.d_wdata = '0; bus.d_byte_enable = '0;
    bus.mem_rdata = '0; bus.mem_resp = 0;
    rst = 1'b1;
    #3;
    chk1 ("rst_mem_read",  bus.mem_read,  1'b0);
    chk1 ("rst_mem_write", bus.mem_write, 1'b0);
    chk16("rst_mem_addr",  bus.mem_address, 16'h0000);
    chk16("rst_mem_wdata", bus.mem_wdata,   16'h0000);
    chk16("rst_mem_be",    16'(bus.mem_byte_enable), 16'h0003);
    chk1 ("rst_i_resp",    bus.i_resp, 1'b0);
    chk1 ("rst_d_resp",    bus.d_resp, 1'b0);
    tick();
    #2 rst = 1'b0;
    prio_d = 1'b1;
    tick();

    // A stray mem_resp in IDLE must not reach either client.
    bus.mem_resp = 1'b1;
    #1;
    chk1("stray_i_resp", bus.i_resp, 1'b0);
    chk1("stray_d_resp", bus.d_resp, 1'b0);
    tick();
    bus.mem_resp = 1'b0;
    #1;
    chk1("stray_mem_read", bus.mem_read, 1'b0);
    tick();

    // Fetch alone
    ref_mem[8'h40] = 16'h1234;
    do_txns(0, 0, '0, '0, '0, 1, 16'h0040, 1, 3, "fetch");

    // Data write with a partial mask
    do_txns(0, 1, 16'h8000, 16'hBEEF, 2'b01, 0, '0, 2, 1, "dwrite");

    // Contention: both in the same cycle (d_address is scrambled in service)
    do_txns(1, 0, 16'h0100, '0, '0, 1, 16'h0002, 2, 2, "contend");

    // d_read and d_write together: write only
    do_txns(1, 1, 16'h0010, 16'hA5C3, 2'b11, 0, '0, 1, 1, "rdwr");

    // Input change mid-service: mem_address stays on the granted address
    bus.d_read = 1'b1;
    bus.d_address = 16'h0100;
    tick();
    bus.d_address = 16'h0200;
    #1;
    chk16("chg_mem_addr", bus.mem_address, 16'h0100);
    serve_d(1, 0, 16'h0100, '0, '0, 2, "chg");
    tick();

    // Async reset in the middle of a fetch
    bus.i_read = 1'b1;
    bus.i_address = 16'h0777;
    tick();
    chk1("arst_pre_read", bus.mem_read, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1 ("arst_mem_read", bus.mem_read, 1'b0);
    chk1 ("arst_i_resp",   bus.i_resp,   1'b0);
    chk16("arst_mem_addr", bus.mem_address, 16'h0000);
    bus.i_read = 1'b0;
    #2 rst = 1'b0;
    prio_d = 1'b1;
    tick();
    bus.mem_rdata = 16'hDEAD;
    bus.mem_resp  = 1'b1;
    #1;
    chk1("arst_late_i_resp", bus.i_resp, 1'b0);
    chk1("arst_late_d_resp", bus.d_resp, 1'b0);
    tick();
    bus.mem_resp = 1'b0;
    #1;
    chk1("arst_idle_read", bus.mem_read, 1'b0);
    tick();

    // Randomized request mixes
    for (int n = 0; n < 40; n++) begin
      int  mix = $urandom_range(0, 2);   // 0 data only, 1 fetch only, 2 both
      int  op  = $urandom_range(0, 2);   // 0 read, 1 write, 2 read+write
      bit  drd = (mix != 1) && (op != 1);
      bit  dwr = (mix != 1) && (op != 0);
      do_txns(drd, dwr, lc3b_addr'($urandom), lc3b_word'($urandom),
              lc3b_mem_wmask'($urandom), (mix != 0), lc3b_addr'($urandom),
              $urandom_range(1, 4), $urandom_range(1, 4), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-client memory arbiter between the pipeline's instruction-fetch port (read-only) and data-memory port (read/write) and the single physical memory port of the mp3 core.
- Moore FSM grants one client at a time.
- Address, write data and byte mask are captured at grant and held for the whole transaction.
- The memory response is steered back to the granted client.
- A mandatory one-cycle idle gap separates transactions.

Parameters:
- ADDR_WIDTH, 16, width of the word address on all ports.
- DATA_WIDTH, 16, width of read/write data.
- MASK_WIDTH, 2, byte-enable width (DATA_WIDTH/8).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_read  in  1  fetch read request; held until i_resp.
- i_address  in  ADDR_WIDTH  fetch address.
- i_rdata  out  DATA_WIDTH  fetch read data; equals mem_rdata.
- i_resp  out  1  fetch transaction complete, 1 cycle.
- d_read  in  1  data read request; held until d_resp.
- d_write  in  1  data write request; held until d_resp.
- d_address  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  data write value.
- d_byte_enable  in  MASK_WIDTH  data write mask.
- d_rdata  out  DATA_WIDTH  data read value; equals mem_rdata.
- d_resp  out  1  data transaction complete, 1 cycle.
- mem_read  out  1  physical memory read strobe.
- mem_write  out  1  physical memory write strobe.
- mem_address  out  ADDR_WIDTH  latched address.
- mem_wdata  out  DATA_WIDTH  latched write data.
- mem_byte_enable  out  MASK_WIDTH  latched mask; all-ones on reads.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_resp  in  1  memory completion, 1 cycle.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port rst.
- States: IDLE, SERVE_I, SERVE_D, GAP.
- Reset (async, any state): state=IDLE, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=all-ones, i_resp=0, d_resp=0, priority flag=D. A mem_resp arriving after reset is ignored because the FSM is in IDLE.
- IDLE:
  - If d_read|d_write: latch d_address, d_wdata and d_byte_enable (all-ones if read) -> SERVE_D.
  - Else if i_read: latch i_address, mask all-ones -> SERVE_I.
  - Else stay.
  - Fixed priority: data beats fetch, because data is the older instruction.
- SERVE_D:
  - mem_write = latched write, mem_read = latched read; both are registered, Moore.
  - d_write and d_read both high: write wins, read is ignored.
  - On mem_resp: d_resp=1 combinationally this cycle, d_rdata=mem_rdata -> GAP.
- SERVE_I:
  - mem_read=1.
  - On mem_resp: i_resp=1 combinationally, i_rdata=mem_rdata -> GAP.
- GAP:
  - Strobes low, no responses -> IDLE unconditionally.
  - Guarantees memory sees a deasserted strobe between transactions.
- Latency: request seen in IDLE at cycle N -> strobe high at N+1. Response is same-cycle pass-through of mem_resp. Minimum request-to-request pitch is 3 cycles plus memory latency.
- Responses are only ever asserted to the granted client; the other client's resp is 0.
- A request arriving while the other client is being served is held by the client and granted after GAP.
- A client dropping its request mid-service is a protocol violation. The arbiter still completes the memory transaction, and the resp pulse is emitted regardless.
- Latched fields do not change during SERVE_*, even if client inputs change.

Optional Feature:
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - The priority flag toggles to the other client after every completed transaction.
  - In IDLE with both requesting, the flagged client wins.
  - Bounds fetch starvation to one data transaction.
- Undefined: fixed data priority; the flag register is not instantiated.

Decomposition:
- lc3b_types package holds:
  - lc3b_word and lc3b_mem_wmask, used for the port types.
  - An arb_state_t enum {IDLE, SERVE_I, SERVE_D, GAP}.
  - A localparam for the all-ones read mask.
- One natural sub-module: arb_req_latch. It is a register bundle holding address, wdata, mask and read/write flags, loaded on grant. Reused for both clients via a mux at its input.

Test Plan:
- Fetch alone: i_read=1, i_address=0x0040; memory responds 3 cycles later with 0x1234 -> mem_read at N+1, mem_address=0x0040, i_resp pulse with i_rdata=0x1234, d_resp=0, then one GAP cycle with mem_read=0.
- Data write: d_write=1, d_address=0x8000, d_wdata=0xBEEF, mask=2'b01 -> mem_write=1, mem_wdata=0xBEEF, mem_byte_enable=2'b01; d_resp on mem_resp.
- Contention: d_read and i_read raised in the same cycle, d_address=0x0100, i_address=0x0002 -> data served first (mem_address=0x0100), GAP, then fetch (mem_address=0x0002). With MEM_ARBITER_ROUND_ROBIN_EN and the flag on I after a prior data transaction, fetch goes first.
- Input change mid-service: change d_address 0x0100->0x0200 during SERVE_D -> mem_address stays 0x0100 until resp.
- Async reset mid-SERVE_I: assert rst between clock edges -> mem_read=0 immediately, state IDLE. A later mem_resp produces no i_resp/d_resp.
- d_read and d_write both high, d_address=0x0010 -> only mem_write=1, mem_read=0.
